fp_divide: RTL
==============

// Module: fp_divide
// PURPOSE
//  Iterative IEEE-754 single-precision divider (op1 / op2); inverse operation to the FP multiplier, same handshake.
//  Sits beside the multiplier in the FP datapath; the controller pulses start, waits for done, then reads result/flags.
//  Restoring mantissa division, one quotient bit per clock. Round toward zero; denormal inputs flush to zero.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MANT_W  23   stored fraction width (hidden bit implicit)
//  BIAS    127  exponent bias
// PORTS
//  clk           in   1   system clock, rising edge
//  n_rst         in   1   asynchronous active-low reset
//  div_start     in   1   request; sampled in IDLE only
//  op1           in   32  dividend {sign, exp, frac}
//  op2           in   32  divisor
//  div_result    out  32  quotient; registered, held until next completion
//  div_done      out  1   one-cycle pulse, result/flags valid
//  div_overflow  out  1   exponent overflow; held with result
//  div_by_zero   out  1   op2 == 0 (incl. flushed denormal); held with result
// BEHAVIOUR
//  Reset (async, n_rst=0): state IDLE; div_result=0, div_done=0, div_overflow=0, div_by_zero=0; internal regs cleared.
//  FSM: IDLE -> LOAD -> DIVIDE -> NORM -> DONE -> IDLE.
//   IDLE: div_start=1 latches op1/op2 -> LOAD. div_start in any other state is ignored (no queueing).
//   LOAD: unpack; sign = s1^s2; exponent e = e1 - e2 + BIAS in 10-bit signed; mantissas m = {1,frac} (24b).
//         Special cases go straight to DONE: op2 zero -> div_by_zero=1, result {sign,8'hFF,0};
//         0/0 -> result 32'h7FC00000, div_by_zero=1; op1 zero (op2 nonzero) -> result {sign,31'b0}.
//         exp field 0 counts as zero (denormal flush); exp 8'hFF inputs are undefined (not checked).
//   DIVIDE: 25 cycles, restoring: rem = rem - m2 if rem >= m2 (q bit 1) else keep (q bit 0); rem <<= 1. Counter 24..0.
//   NORM: if q[24]==0 then q <<= 1, e -= 1. Fraction = q[23:1] (truncation).
//         e >= 255 -> result {sign,8'hFF,0}, div_overflow=1. e <= 0 -> result {sign,31'b0} (underflow, no flag).
//   DONE: div_result/flags registered; div_done=1 for exactly this cycle -> IDLE.
//  Latency: start sampled at edge 0; normal path div_done high after edge 28 (LOAD 1 + DIVIDE 25 + NORM 1 + DONE 1);
//   special-case path div_done high after edge 2. Back-to-back: new start accepted the cycle after DONE.
//  Flags/result from previous op persist until the next DONE overwrites them (flags cleared on that DONE if not set).
//  div_start held high continuously re-triggers every operation; operand changes mid-operation have no effect.
//  Reset mid-operation: abort immediately, outputs to reset values, no div_done pulse.
// STRUCTURE
//  fp_pkg: EXP_W, MANT_W, BIAS constants; typedef struct packed {sign; exp; frac} fp32_t;
//   typedef enum {IDLE, LOAD, DIVIDE, NORM, DONE} div_state_t (multiplier controller may reuse fp32_t).
//  Sub-module fp_mant_div: 24-bit restoring mantissa divider core (load, step, 25-bit quotient, step counter);
//   top handles FSM, unpack/special cases, exponent, normalisation, packing, output registers.
// TESTING
//  Check result exactly at div_done and on every following cycle until the next start.
//  1) 6.0/2.0: 40C00000 / 40000000 -> 40400000, flags 0, div_done 28 cycles after start.
//  2) 3.0/-1.5: 40400000 / BFC00000 -> C0000000; -12.0/-4.0: C1400000 / C0800000 -> 40400000.
//  3) 1.0/3.0: 3F800000 / 40400000 -> 3EAAAAAA (truncated, not AB); pi/4 3F490FDB / 1.0 -> 3F490FDB.
//  4) div-by-zero: 3F800000 / 00000000 -> 7F800000, div_by_zero=1, done after 2 cycles; 0/0 -> 7FC00000;
//     00000000 / 40400000 -> 00000000, flags 0.
//  5) overflow: 7F000000 / 00800000 -> 7F800000, div_overflow=1; underflow: 00800000 / 7F000000 -> 00000000.
//  6) reset mid-DIVIDE (cycle 10): all outputs 0, no done pulse; next 6.0/2.0 completes normally in 28 cycles;
//     div_start pulsed during DIVIDE with new operands -> ignored, original result returned.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision field widths, operand layout and divider states
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;
  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, NORM, DONE} div_state_t;
endpackage

// File: rtl/fp_mant_div.sv
// fp_mant_div: restoring mantissa divider, one quotient bit per step, MANT_W+2 steps
module fp_mant_div
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              step,
  input  logic [MANT_W:0]   dividend,
  input  logic [MANT_W:0]   divisor,
  output logic [MANT_W+1:0] quot,
  output logic              last
);
  logic [MANT_W+1:0] rem;
  logic [MANT_W:0]   dvs;
  logic [4:0]        cnt;
  logic              ge;
  assign ge   = rem >= {1'b0, dvs};
  assign last = cnt == 5'd0;
  // rem stays below 2*divisor, so the shifted-out MSB is always zero
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      quot <= '0;
    end else if (load) begin
      rem  <= {1'b0, dividend};
      dvs  <= divisor;
      cnt  <= 5'(MANT_W + 1);
      quot <= '0;
    end else if (step) begin
      rem  <= (ge ? rem - {1'b0, dvs} : rem) << 1;
      quot <= {quot[MANT_W:0], ge};
      cnt  <= cnt - 5'd1;
    end
endmodule

// File: rtl/fp_divide.sv
// fp_divide: iterative single-precision divider, round toward zero, denormals flushed
module fp_divide
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        div_start,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] div_result,
  output logic        div_done,
  output logic        div_overflow,
  output logic        div_by_zero
);
  div_state_t state, nxt;
  fp32_t a, b;
  logic              sgn, a_z, b_z, s_in, ld, st, last, ovf_p, dbz_p;
  logic signed [9:0] e, en;
  logic [31:0]       res_p;
  logic [MANT_W+1:0] q;
  logic [MANT_W-1:0] frac;
  assign a_z  = a.exp == '0;
  assign b_z  = b.exp == '0;
  assign s_in = a.sign ^ b.sign;
  fp_mant_div u_mant (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (ld),
    .step     (st),
    .dividend ({1'b1, a.frac}),
    .divisor  ({1'b1, b.frac}),
    .quot     (q),
    .last     (last)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE   ? (div_start ? LOAD : IDLE) :
          state == LOAD   ? ((a_z | b_z) ? DONE : DIVIDE) :
          state == DIVIDE ? (last ? NORM : DIVIDE) :
          state == NORM   ? DONE : IDLE;
  always_comb begin
    ld = state == LOAD;
    st = state == DIVIDE;
  end
  // quotient lies in (0.5, 2): a clear top bit needs one left shift
  always_comb begin
    en   = q[MANT_W+1] ? e : e - 10'sd1;
    frac = q[MANT_W+1] ? q[MANT_W:1] : q[MANT_W-1:0];
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      a            <= '0;
      b            <= '0;
      sgn          <= 1'b0;
      e            <= '0;
      res_p        <= '0;
      ovf_p        <= 1'b0;
      dbz_p        <= 1'b0;
      div_result   <= '0;
      div_done     <= 1'b0;
      div_overflow <= 1'b0;
      div_by_zero  <= 1'b0;
    end else begin
      if (state == IDLE && div_start) begin
        a <= op1;
        b <= op2;
      end
      if (state == LOAD) begin
        sgn   <= s_in;
        e     <= 10'(a.exp) - 10'(b.exp) + 10'(BIAS);
        ovf_p <= 1'b0;
        dbz_p <= b_z;
        res_p <= b_z ? (a_z ? 32'h7FC0_0000 : {s_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}}) : {s_in, 31'b0};
      end
      if (state == NORM) begin
        ovf_p <= en >= 10'sd255;
        res_p <= en >= 10'sd255 ? {sgn, {EXP_W{1'b1}}, {MANT_W{1'b0}}} :
                 en <= 10'sd0   ? {sgn, 31'b0} : {sgn, en[EXP_W-1:0], frac};
      end
      div_done <= state == DONE;
      if (state == DONE) begin
        div_result   <= res_p;
        div_overflow <= ovf_p;
        div_by_zero  <= dbz_p;
      end
    end
endmodule
